// File: rtl/pse_defs_pkg.sv
// -----------------------------------------------------------------------------
// pse_defs
// Shared definitions for the priority scan encoder family:
//   - pse_state_e : scan FSM state encoding (IDLE / SCAN)
//   - clog2_f     : ceiling log2, used to size index ports from N
// -----------------------------------------------------------------------------
package pse_defs;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } pse_state_e;

    // Smallest w with 2**w >= n; evaluated at elaboration time only.
    function automatic int clog2_f(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/priority_scan_encoder_enc.sv
// -----------------------------------------------------------------------------
// prio_enc_n
// Combinational N-to-W priority encoder; the generalised 8-to-3 encoder.
// Parameters:
//   N         request width (>= 2)
//   MSB_FIRST 1: highest set index wins, 0: lowest set index wins
// Ports:
//   req_i  [N-1:0]  request vector
//   idx_o  [W-1:0]  index of the winning request (0 when none set)
//   any_o           at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc_n
    import pse_defs::*;
#(
    parameter int  N         = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int W         = clog2_f(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W-1:0] idx_s;

    // Walk toward the winning end so the last match seen is the winner.
    always_comb begin
        idx_s = {W{1'b0}};
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i]) begin
                    idx_s = W'(i);
                end else begin
                    idx_s = idx_s;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    idx_s = W'(i);
                end else begin
                    idx_s = idx_s;
                end
            end
        end
    end

    assign idx_o = idx_s;
    assign any_o = |req_i;

endmodule

// File: rtl/priority_scan_encoder.sv
// -----------------------------------------------------------------------------
// priority_scan_encoder
// Accepts an N-bit request vector on a valid/ready handshake and emits the
// index of every set bit, one per transfer, in priority order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_vec/in_valid/in_ready     request vector handshake
//   out_idx/out_valid/out_ready  index stream handshake
//   out_last              current index is the final set bit of the vector
//   zero_drop             one-cycle pulse: all-zero vector accepted and dropped
//   busy                  a vector is being scanned
// -----------------------------------------------------------------------------
module priority_scan_encoder
    import pse_defs::*;
#(
    parameter int  N         = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int W         = clog2_f(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         zero_drop,
    output logic         busy
);

    pse_state_e   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_drop_q, zero_drop_d;

    logic [W-1:0] idx_s;
    logic         any_s;
    logic         last_s;
    logic         transfer_s;
    logic         accept_s;
    logic [N-1:0] onehot_s;

    prio_enc_n #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .req_i (pending_q),
        .idx_o (idx_s),
        .any_o (any_s)
    );

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign last_s     = any_s & ((pending_q & (pending_q - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
    assign transfer_s = (state_q == ST_SCAN) & out_ready;
    // Ready also on the final transfer so a new vector follows with no bubble.
    assign in_ready   = (state_q == ST_IDLE) | (transfer_s & last_s);
    assign accept_s   = in_valid & in_ready;

    // Decode the current index into the bit to clear on a transfer.
    always_comb begin
        onehot_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            onehot_s[i] = (idx_s == W'(i));
        end
    end

    // Next-state: accept has priority since it only coincides with a last transfer.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        if (accept_s) begin
            if (|in_vec) begin
                pending_d = in_vec;
                state_d   = ST_SCAN;
            end else begin
                pending_d   = {N{1'b0}};
                state_d     = ST_IDLE;
                zero_drop_d = 1'b1;
            end
        end else if (transfer_s) begin
            pending_d = pending_q & ~onehot_s;
            if (last_s) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_SCAN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // FSM, pending vector and drop pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= {N{1'b0}};
            zero_drop_q <= 1'b0;
        end else begin
            case (state_d)
                ST_IDLE: state_q <= ST_IDLE;
                ST_SCAN: state_q <= ST_SCAN;
                default: state_q <= ST_IDLE;
            endcase
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    assign out_idx   = idx_s;
    assign out_last  = last_s;
    assign out_valid = (state_q == ST_SCAN);
    assign busy      = (state_q == ST_SCAN);
    assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_vec;
    logic       in_valid, out_ready;

    logic       in_ready, out_valid, out_last, zero_drop, busy;
    logic [2:0] out_idx;
    logic       l_in_ready, l_out_valid, l_out_last, l_zero_drop, l_busy;
    logic [2:0] l_out_idx;

    logic [11:0] in12_vec;
    logic        in12_valid, out12_ready;
    logic        in12_ready, out12_valid, out12_last, zero12_drop, busy12;
    logic [3:0]  out12_idx;

    priority_scan_encoder #(.N(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .zero_drop(zero_drop), .busy(busy));

    priority_scan_encoder #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(l_in_ready),
        .out_idx(l_out_idx), .out_valid(l_out_valid), .out_ready(out_ready), .out_last(l_out_last),
        .zero_drop(l_zero_drop), .busy(l_busy));

    priority_scan_encoder #(.N(12), .MSB_FIRST(1'b1)) u_n12 (
        .clk(clk), .rst_n(rst_n), .in_vec(in12_vec), .in_valid(in12_valid), .in_ready(in12_ready),
        .out_idx(out12_idx), .out_valid(out12_valid), .out_ready(out12_ready), .out_last(out12_last),
        .zero_drop(zero12_drop), .busy(busy12));

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } exp_t;

    exp_t q_msb[$];
    exp_t q_lsb[$];
    exp_t q12[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected index streams for both scan orders of an 8-bit vector.
    function automatic void model_push8(input logic [7:0] v);
        int pc, k;
        exp_t e;
        pc = $countones(v);
        k = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                k++;
                e.idx = 4'(i); e.last = (k == pc);
                q_msb.push_back(e);
            end
        end
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                k++;
                e.idx = 4'(i); e.last = (k == pc);
                q_lsb.push_back(e);
            end
        end
    endfunction

    function automatic void model_push12(input logic [11:0] v);
        int pc, k;
        exp_t e;
        pc = $countones(v);
        k = 0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) begin
                k++;
                e.idx = 4'(i); e.last = (k == pc);
                q12.push_back(e);
            end
        end
    endfunction

    // Output monitors: sample mid low phase, pop on every transfer.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid && out_ready) begin
            if (q_msb.size() == 0) chk("msb_spurious", 32'd1, 32'd0);
            else begin
                e = q_msb.pop_front();
                chk("msb_idx", 32'(out_idx), 32'(e.idx));
                chk("msb_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (l_out_valid && out_ready) begin
            if (q_lsb.size() == 0) chk("lsb_spurious", 32'd1, 32'd0);
            else begin
                e = q_lsb.pop_front();
                chk("lsb_idx", 32'(l_out_idx), 32'(e.idx));
                chk("lsb_last", 32'(l_out_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out12_valid && out12_ready) begin
            if (q12.size() == 0) chk("n12_spurious", 32'd1, 32'd0);
            else begin
                e = q12.pop_front();
                chk("n12_idx", 32'(out12_idx), 32'(e.idx));
                chk("n12_last", 32'(out12_last), 32'(e.last));
            end
        end
    end

    // Present a vector, hold until accepted, then check one-cycle latency.
    task automatic send8(input logic [7:0] v, input string tag);
        int n;
        @(negedge clk);
        in_vec   = v;
        in_valid = 1'b1;
        model_push8(v);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, 32'(n < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 8'h5A;
        chk({tag, "_latency"}, 32'(out_valid), 32'(v != 8'h00));
        chk({tag, "_lsb_latency"}, 32'(l_out_valid), 32'(v != 8'h00));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_msb.size() != 0 || q_lsb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_drain_msb"}, 32'(q_msb.size()), 32'd0);
        chk({tag, "_drain_lsb"}, 32'(q_lsb.size()), 32'd0);
        chk({tag, "_idle_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        int n;
        rst_n       = 1'b0;
        in_vec      = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in12_vec    = 12'h000;
        in12_valid  = 1'b0;
        out12_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_zero_drop", 32'(zero_drop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // One-hot walk
        for (int i = 0; i < 8; i++) begin
            v = 8'd1 << i;
            send8(v, "onehot");
        end
        drain("onehot");

        // Mixed vector, both scan orders in parallel
        send8(8'hD5, "d5");
        drain("d5");

        // All-zero vector is dropped
        send8(8'h00, "zero");
        chk("zero_pulse", 32'(zero_drop), 32'd1);
        chk("zero_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("zero_pulse_end", 32'(zero_drop), 32'd0);
        chk("zero_no_valid", 32'(out_valid), 32'd0);
        chk("zero_in_ready2", 32'(in_ready), 32'd1);

        // Backpressure
        out_ready = 1'b0;
        send8(8'h24, "bp");
        for (int i = 0; i < 3; i++) begin
            chk("bp_idx", 32'(out_idx), 32'd5);
            chk("bp_last", 32'(out_last), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain("bp");

        // Back-to-back with accept on the last transfer edge
        send8(8'h03, "b2b_a");
        send8(8'h80, "b2b_b");
        drain("b2b");

        // All-ones vector
        send8(8'hFF, "ones");
        drain("ones");

        // Reset during a scan
        send8(8'hFF, "rstscan");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        q_msb.delete();
        q_lsb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        send8(8'h01, "recover");
        drain("recover");

        // N = 12, all ones
        @(negedge clk);
        in12_vec   = 12'hFFF;
        in12_valid = 1'b1;
        model_push12(12'hFFF);
        n = 0;
        while (!in12_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("n12_accept_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in12_valid = 1'b0;
        chk("n12_latency", 32'(out12_valid), 32'd1);
        n = 0;
        while (q12.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("n12_drain", 32'(q12.size()), 32'd0);
        chk("n12_idle_after", 32'(out12_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
